// File: rtl/drive_sel_pkg.sv
// drive_sel_pkg: shared state encoding and source indices for drive source selection
package drive_sel_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, BLANK, SWITCH} state_t;
  localparam int SRC_NORMAL = 0;
  localparam int SRC_STM = 1;
endpackage

// File: rtl/time_boundary_detector.sv
// time_boundary_detector: flags every toggle of SYS_TIME[PERIOD_LOG2]
module time_boundary_detector #(
  parameter int PERIOD_LOG2 = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] SYS_TIME,
  output logic        EDGE
);
  logic bit_q;
  logic unused_time;
  assign unused_time = ^SYS_TIME;
  always_ff @(posedge CLK or posedge RST)
    if (RST) bit_q <= 1'b0;
    else bit_q <= SYS_TIME[PERIOD_LOG2];
  assign EDGE = SYS_TIME[PERIOD_LOG2] ^ bit_q;
endmodule

// File: rtl/drive_source_selector.sv
// drive_source_selector: boundary-sequenced, optionally blanked selection of one duty/phase source
module drive_source_selector
  import drive_sel_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249,
  parameter int NUM_SRC = 4,
  parameter int PERIOD_LOG2 = 9,
  parameter int BLANK_PERIODS = 2,
  localparam int SRC_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic [63:0]                               SYS_TIME,
  input  logic                                      REQ,
  input  logic [SRC_W-1:0]                          MODE_NEXT,
  input  logic [NUM_SRC-1:0]                        SRC_EN,
  input  logic [NUM_SRC-1:0][DEPTH-1:0][WIDTH-1:0]  DUTY_IN,
  input  logic [NUM_SRC-1:0][DEPTH-1:0][WIDTH-1:0]  PHASE_IN,
  output logic [DEPTH-1:0][WIDTH-1:0]               DUTY_OUT,
  output logic [DEPTH-1:0][WIDTH-1:0]               PHASE_OUT,
  output logic [SRC_W-1:0]                          MODE_CUR,
  output logic                                      BUSY,
  output logic                                      ACK,
  output logic                                      ERR,
  output logic                                      DONE
);
  localparam int BW = (BLANK_PERIODS > 1) ? $clog2(BLANK_PERIODS + 1) : 1;
  state_t state, state_n;
  logic [SRC_W-1:0] next_q, next_n, mode_n, sel;
  logic [BW-1:0] blank_cnt, cnt_n;
  logic ack_n, err_n, done_n, bnd, req_ok, zero;

  time_boundary_detector #(.PERIOD_LOG2(PERIOD_LOG2)) u_bnd (
    .CLK(CLK), .RST(RST), .SYS_TIME(SYS_TIME), .EDGE(bnd)
  );

  assign req_ok = ({1'b0, MODE_NEXT} < (SRC_W + 1)'(NUM_SRC)) && SRC_EN[MODE_NEXT];
  assign BUSY = state != IDLE;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      next_q <= '0;
      blank_cnt <= '0;
      MODE_CUR <= SRC_W'(SRC_NORMAL);
      ACK <= 1'b0;
      ERR <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_n;
      next_q <= next_n;
      blank_cnt <= cnt_n;
      MODE_CUR <= mode_n;
      ACK <= ack_n;
      ERR <= err_n;
      DONE <= done_n;
    end

  always_comb begin
    state_n = state;
    next_n = next_q;
    cnt_n = blank_cnt;
    mode_n = MODE_CUR;
    ack_n = 1'b0;
    err_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: if (REQ) begin
        err_n = !req_ok;
        ack_n = req_ok;
        done_n = req_ok && MODE_NEXT == MODE_CUR;
        if (req_ok && MODE_NEXT != MODE_CUR) begin
          next_n = MODE_NEXT;
          state_n = WAIT_EDGE;
        end
      end
      WAIT_EDGE, BLANK: if (!SRC_EN[next_q]) begin
        err_n = 1'b1;
        state_n = IDLE;
      end else if (bnd) begin
        if (state == WAIT_EDGE) begin
          cnt_n = BW'(BLANK_PERIODS);
          state_n = (BLANK_PERIODS == 0) ? SWITCH : BLANK;
        end else begin
          cnt_n = blank_cnt - 1'b1;
          state_n = (blank_cnt == BW'(1)) ? SWITCH : BLANK;
        end
      end
      SWITCH: begin
        mode_n = next_q;
        done_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // the SWITCH cycle already loads the new source so outputs, MODE_CUR and DONE change together
  assign sel = (state == SWITCH) ? next_q : MODE_CUR;
  assign zero = (state == BLANK) || !SRC_EN[sel];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ch
    logic [WIDTH-1:0] d_q, p_q;
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        d_q <= '0;
        p_q <= '0;
      end else begin
        d_q <= zero ? '0 : DUTY_IN[sel][i];
        p_q <= PHASE_IN[sel][i];
      end
    assign DUTY_OUT[i] = d_q;
    assign PHASE_OUT[i] = p_q;
  end
endmodule

// File: tb/tb_drive_source_selector.sv
// tb_drive_source_selector: directed scenarios plus random traffic against an edge-counting model
module tb_drive_source_selector;
  localparam int WIDTH = 13, DEPTH = 8, NS = 4, PL = 3, BP = 2, SW = 2;
  typedef logic [DEPTH-1:0][WIDTH-1:0] arr_t;

  logic clk = 0, rst = 1, req = 0, req0 = 0;
  logic [63:0] sys_time = 0;
  logic [SW-1:0] mode_next = 0;
  logic [NS-1:0] src_en = 4'b0011;
  logic [NS-1:0][DEPTH-1:0][WIDTH-1:0] duty_in, phase_in;
  arr_t duty_out, phase_out, duty0, phase0;
  logic [SW-1:0] mode_cur, mode0;
  logic busy, ack, err, done, busy0, ack0, err0, done0;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  drive_source_selector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SRC(NS), .PERIOD_LOG2(PL), .BLANK_PERIODS(BP)) u_dut (
    .CLK(clk), .RST(rst), .SYS_TIME(sys_time), .REQ(req), .MODE_NEXT(mode_next), .SRC_EN(src_en),
    .DUTY_IN(duty_in), .PHASE_IN(phase_in), .DUTY_OUT(duty_out), .PHASE_OUT(phase_out),
    .MODE_CUR(mode_cur), .BUSY(busy), .ACK(ack), .ERR(err), .DONE(done)
  );

  drive_source_selector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SRC(NS), .PERIOD_LOG2(PL), .BLANK_PERIODS(0)) u_dut0 (
    .CLK(clk), .RST(rst), .SYS_TIME(sys_time), .REQ(req0), .MODE_NEXT(mode_next), .SRC_EN(src_en),
    .DUTY_IN(duty_in), .PHASE_IN(phase_in), .DUTY_OUT(duty0), .PHASE_OUT(phase0),
    .MODE_CUR(mode0), .BUSY(busy0), .ACK(ack0), .ERR(err0), .DONE(done0)
  );

  // reference model for u_dut: counts boundaries since acceptance; the (BP+1)th one triggers the switch
  int m_mode, m_tgt, m_edges, sel_m;
  logic m_busy, m_sw, m_prev, e_m, blank_m;
  arr_t exp_duty, exp_phase;
  logic exp_ack, exp_err, exp_done;

  always_comb begin
    e_m = sys_time[PL] != m_prev;
    sel_m = m_sw ? m_tgt : m_mode;
    blank_m = m_busy && !m_sw && m_edges > 0;
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_mode <= 0; m_tgt <= 0; m_edges <= 0; m_busy <= 0; m_sw <= 0; m_prev <= 0;
      exp_duty <= '0; exp_phase <= '0; exp_ack <= 0; exp_err <= 0; exp_done <= 0;
    end else begin
      m_prev <= sys_time[PL];
      exp_ack <= 0; exp_err <= 0; exp_done <= 0;
      for (int i = 0; i < DEPTH; i++) begin
        exp_duty[i] <= (blank_m || !src_en[sel_m]) ? '0 : duty_in[sel_m][i];
        exp_phase[i] <= phase_in[sel_m][i];
      end
      if (!m_busy) begin
        if (req) begin
          if (int'(mode_next) >= NS || !src_en[mode_next]) exp_err <= 1;
          else if (int'(mode_next) == m_mode) begin exp_ack <= 1; exp_done <= 1; end
          else begin exp_ack <= 1; m_busy <= 1; m_tgt <= int'(mode_next); m_edges <= 0; m_sw <= 0; end
        end
      end else if (m_sw) begin
        m_mode <= m_tgt; exp_done <= 1; m_busy <= 0; m_sw <= 0;
      end else if (!src_en[m_tgt]) begin
        exp_err <= 1; m_busy <= 0;
      end else if (e_m) begin
        m_edges <= m_edges + 1;
        if (m_edges + 1 == BP + 1) m_sw <= 1;
      end
    end

  function automatic arr_t fill(int v);
    arr_t r;
    for (int i = 0; i < DEPTH; i++) r[i] = WIDTH'(v);
    return r;
  endfunction

  task automatic set_src(int s, int d, int p);
    duty_in[s] = fill(d);
    phase_in[s] = fill(p);
  endtask

  task automatic cyc();
    @(negedge clk);
    sys_time = sys_time + 1;
  endtask

  task automatic align(int m);
    while (int'(sys_time[2:0]) != m) cyc();
  endtask

  task automatic test_reset();
    rst = 1; src_en = 4'b0011;
    set_src(0, 100, 7); set_src(1, 200, 50); set_src(2, 300, 60); set_src(3, 400, 70);
    cyc(); cyc();
    n_cmp++; if (duty_out !== fill(0)) begin n_fail++; $display("FAIL reset_duty: got %h exp %h", duty_out, fill(0)); end
    n_cmp++; if (mode_cur !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_state: mode %0d busy %b exp 0 0", mode_cur, busy); end
    rst = 0;
    cyc();
    n_cmp++; if (duty_out !== fill(100)) begin n_fail++; $display("FAIL release_duty: got %h exp %h", duty_out, fill(100)); end
    n_cmp++; if (phase_out !== fill(7)) begin n_fail++; $display("FAIL release_phase: got %h exp %h", phase_out, fill(7)); end
  endtask

  // request at an arbitrary offset; returns cycles to DONE and count of zero-duty cycles
  task automatic run_change(input int tgt, input int offs, input int old_phase, output int lat, output int zeros);
    int bad_phase;
    bit got;
    align(offs);
    req = 1; mode_next = SW'(tgt);
    cyc();
    req = 0;
    n_cmp++; if (ack !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL accept_ack: ack %b busy %b exp 1 1", ack, busy); end
    lat = 0; zeros = 0; bad_phase = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      cyc(); lat++;
      if (done) got = 1;
      else if (duty_out == fill(0)) begin
        zeros++;
        if (phase_out !== fill(old_phase)) bad_phase++;
      end
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL change_timeout: done not seen after %0d cycles", lat); end
    n_cmp++; if (bad_phase != 0) begin n_fail++; $display("FAIL blank_phase: %0d cycles with phase not %0d", bad_phase, old_phase); end
  endtask

  task automatic test_switch();
    int lat, zeros;
    run_change(1, 3, 7, lat, zeros);
    n_cmp++; if (lat != 22) begin n_fail++; $display("FAIL switch_latency: got %0d exp 22", lat); end
    n_cmp++; if (zeros != 16) begin n_fail++; $display("FAIL switch_blank_cycles: got %0d exp 16", zeros); end
    n_cmp++; if (mode_cur !== 2'd1) begin n_fail++; $display("FAIL switch_mode: got %0d exp 1", mode_cur); end
    n_cmp++; if (duty_out !== fill(200) || phase_out !== fill(50)) begin n_fail++; $display("FAIL switch_data: duty %h phase %h exp %h %h", duty_out, phase_out, fill(200), fill(50)); end
  endtask

  task automatic test_err();
    req = 1; mode_next = 2; cyc(); req = 0;
    n_cmp++; if (err !== 1'b1 || ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL disabled_req: err %b ack %b busy %b exp 1 0 0", err, ack, busy); end
    n_cmp++; if (duty_out !== fill(200)) begin n_fail++; $display("FAIL disabled_req_duty: got %h exp %h", duty_out, fill(200)); end
    req = 1; mode_next = 1; cyc(); req = 0;
    n_cmp++; if (ack !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL same_mode: ack %b done %b busy %b exp 1 1 0", ack, done, busy); end
    req = 1; mode_next = 0; cyc(); req = 0;
    n_cmp++; if (ack !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL accept2: ack %b busy %b exp 1 1", ack, busy); end
    req = 1; mode_next = 1; cyc(); req = 0;
    n_cmp++; if (ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL busy_req: ack %b err %b exp 0 0", ack, err); end
    src_en = 4'b0010; cyc();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0 || mode_cur !== 2'd1) begin n_fail++; $display("FAIL abort: err %b busy %b mode %0d exp 1 0 1", err, busy, mode_cur); end
    src_en = 4'b0011; cyc();
  endtask

  task automatic test_coincident();
    int lat, zeros;
    run_change(0, 0, 50, lat, zeros);
    n_cmp++; if (lat != 25) begin n_fail++; $display("FAIL coincident_latency: got %0d exp 25", lat); end
    n_cmp++; if (zeros != 16) begin n_fail++; $display("FAIL coincident_blank_cycles: got %0d exp 16", zeros); end
    n_cmp++; if (mode_cur !== 2'd0 || duty_out !== fill(100)) begin n_fail++; $display("FAIL coincident_end: mode %0d duty %h exp 0 %h", mode_cur, duty_out, fill(100)); end
  endtask

  task automatic test_blank_zero();
    int lat, zeros;
    bit got;
    align(3);
    req0 = 1; mode_next = 1; cyc(); req0 = 0;
    n_cmp++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL bp0_ack: got %b exp 1", ack0); end
    lat = 0; zeros = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      cyc(); lat++;
      if (done0) got = 1;
      if (duty0 == fill(0)) zeros++;
    end
    n_cmp++; if (!got || lat != 6) begin n_fail++; $display("FAIL bp0_latency: got %0d (done %b) exp 6", lat, got); end
    n_cmp++; if (zeros != 0) begin n_fail++; $display("FAIL bp0_zero_cycles: got %0d exp 0", zeros); end
    n_cmp++; if (mode0 !== 2'd1 || duty0 !== fill(200)) begin n_fail++; $display("FAIL bp0_end: mode %0d duty %h exp 1 %h", mode0, duty0, fill(200)); end
  endtask

  task automatic test_rst_mid();
    bit got;
    req = 1; mode_next = 1; cyc(); req = 0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      cyc();
      if (duty_out == fill(0)) got = 1;
    end
    n_cmp++; if (!got || busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_blank: blank %b busy %b exp 1 1", got, busy); end
    #2 rst = 1;
    #1;
    n_cmp++; if (duty_out !== fill(0) || phase_out !== fill(0) || busy !== 1'b0 || mode_cur !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid: duty %h phase %h busy %b mode %0d exp zeros", duty_out, phase_out, busy, mode_cur); end
    n_cmp++; if (mode0 !== 2'd0 || duty0 !== fill(0)) begin n_fail++; $display("FAIL rst_mid_bp0: mode %0d duty %h exp 0", mode0, duty0); end
    cyc(); rst = 0; cyc();
    n_cmp++; if (duty_out !== fill(100)) begin n_fail++; $display("FAIL rst_mid_release: got %h exp %h", duty_out, fill(100)); end
  endtask

  task automatic test_safety();
    src_en = 4'b0010; cyc();
    n_cmp++; if (duty_out !== fill(0) || phase_out !== fill(7)) begin n_fail++; $display("FAIL safety: duty %h phase %h exp %h %h", duty_out, phase_out, fill(0), fill(7)); end
    src_en = 4'b0011; cyc();
    n_cmp++; if (duty_out !== fill(100)) begin n_fail++; $display("FAIL safety_restore: got %h exp %h", duty_out, fill(100)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      req = ($urandom_range(0, 4) == 0);
      mode_next = SW'($urandom);
      if ($urandom_range(0, 19) == 0) src_en = NS'($urandom);
      else if ($urandom_range(0, 29) == 0) src_en = 4'b1111;
      for (int s = 0; s < NS; s++)
        for (int i = 0; i < DEPTH; i++) begin
          duty_in[s][i] = WIDTH'($urandom);
          phase_in[s][i] = WIDTH'($urandom);
        end
      cyc();
      n_cmp++; if (duty_out !== exp_duty) begin n_fail++; $display("FAIL rnd_duty @%0d: got %h exp %h", n, duty_out, exp_duty); end
      n_cmp++; if (phase_out !== exp_phase) begin n_fail++; $display("FAIL rnd_phase @%0d: got %h exp %h", n, phase_out, exp_phase); end
      n_cmp++; if (mode_cur !== SW'(m_mode)) begin n_fail++; $display("FAIL rnd_mode @%0d: got %0d exp %0d", n, mode_cur, m_mode); end
      n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy @%0d: got %b exp %b", n, busy, m_busy); end
      n_cmp++; if ({ack, err, done} !== {exp_ack, exp_err, exp_done}) begin
        n_fail++; $display("FAIL rnd_pulses @%0d: got %b%b%b exp %b%b%b", n, ack, err, done, exp_ack, exp_err, exp_done); end
    end
    req = 0;
  endtask

  initial begin
    duty_in = '0;
    phase_in = '0;
    test_reset();
    test_switch();
    test_err();
    test_coincident();
    test_blank_zero();
    test_rst_mid();
    test_safety();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
